// File: rtl/mult_pkg.sv
// Shared types and defaults for the add-shift multiplier sequencer.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HALT
  } mult_state_t;

  localparam int MULT_WIDTH = 8;

endpackage

// File: rtl/mult_control.sv
// Sequencer for the add-shift multiplier: one ADD and one SHIFT step per
// multiplier bit, with a subtract on the final (sign) bit.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Shift_En,
  output logic Ld_A,
  output logic Ld_B,
  output logic Clr_A,
  output logic Add,
  output logic Sub,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  mult_state_t       state;
  mult_state_t       next_state;
  logic [CNT_W-1:0]  cnt;
  logic              last_bit;

  assign last_bit = (cnt == LAST_BIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        cnt <= '0;
      end else if (state == SHIFT && !last_bit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // HALT only releases on a sampled-low Run so a held Run cannot retrigger.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (Run) next_state = CLEAR;
      CLEAR:   next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = last_bit ? HALT : ADD;
      HALT:    if (!Run) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The last bit carries negative weight, so its partial product is subtracted.
  always_comb begin
    Shift_En = 1'b0;
    Ld_A     = 1'b0;
    Ld_B     = 1'b0;
    Clr_A    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        Clr_A = ClearA_LoadB & ~Run;
        Ld_B  = ClearA_LoadB & ~Run;
      end
      CLEAR: begin
        Clr_A = 1'b1;
        Busy  = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        Ld_A = M;
        Add  = M & ~last_bit;
        Sub  = M & last_bit;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
      end
      HALT: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing FSM for the add-shift multiplier datapath. Drives the Load, Shift_En and clear controls of the A and B shift registers and the add/subtract unit. It steps through one add phase and one shift phase per multiplier bit. The block sits directly upstream of the 4-bit shift-register slices: its Shift_En and load strobes feed every slice. It consumes the multiplier LSB, which is Shift_Out of the low B slice, as input M.

## Interface
- WIDTH, 8, multiplier bit count; number of add/shift iterations; ≥2
- Clk input 1: system clock, rising edge
- Reset input 1: synchronous, active-high
- Run input 1: start request, level-sampled in IDLE
- ClearA_LoadB input 1: clear A and X, load B from switches; honoured only in IDLE
- M input 1: current multiplier LSB (B slice Shift_Out)
- Shift_En output 1: shift the X/A/B chain right one bit
- Ld_A output 1: load adder result into X and A
- Ld_B output 1: parallel-load B
- Clr_A output 1: clear X and A
- Add output 1: adder computes A + S
- Sub output 1: adder computes A − S
- Busy output 1: high in CLEAR, ADD, SHIFT
- Done output 1: high in HALT

## Operation
- All outputs are Moore (functions of state and cnt only) except:
  - Ld_B and Clr_A in IDLE, which follow ClearA_LoadB.
  - Add, Sub and Ld_A in ADD, which depend on M.
- State IDLE:
  - Outputs 0, except Clr_A = Ld_B = ClearA_LoadB.
  - Run=1 → CLEAR. Run has priority: if Run and ClearA_LoadB are both high, Ld_B and Clr_A are 0.
- State CLEAR:
  - Clr_A=1, cnt ← 0.
  - → ADD.
- State ADD:
  - Ld_A = M.
  - Add = M & (cnt ≠ WIDTH−1); Sub = M & (cnt = WIDTH−1), which is the two's-complement sign-bit correction.
  - Add and Sub are never both 1.
  - → SHIFT.
- State SHIFT:
  - Shift_En=1.
  - If cnt = WIDTH−1 → HALT; else cnt ← cnt+1 and → ADD.
- State HALT:
  - Done=1, and all other controls are 0.
  - Run=0 → IDLE; otherwise stay. A held Run never restarts a run.
- cnt width is $clog2(WIDTH) bits; it never wraps within a run.
- Mid-run behaviour:
  - Run deasserting mid-run is ignored; the sequence completes.
  - ClearA_LoadB during Busy or Done is ignored.
  - M is only used in ADD.

## Timing
- Reset sampled high → next cycle:
  - State = IDLE, cnt = 0.
  - All outputs 0, except Clr_A/Ld_B, which follow ClearA_LoadB combinationally.
- Reset applies in any state, including mid-run; there is no partial completion and no Done pulse.
- Latency from the edge that samples Run=1 in IDLE:
  - CLEAR in cycle 1.
  - ADDi in cycle 2+2i; SHIFTi in cycle 3+2i.
  - HALT from cycle 2·WIDTH+2. This is cycle 18 for WIDTH=8.
- Run length: 2·WIDTH+1 cycles of Busy, then Done held until Run is sampled low.
- Exactly WIDTH Shift_En pulses per run, never on consecutive cycles.
- Ld_A, if asserted, always comes one cycle before the matching Shift_En.
- Minimum Run-to-Run spacing: Run must be low for ≥1 sampled edge in HALT before IDLE will accept a new start.

## Structure
- Package mult_pkg holds:
  - typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HALT} mult_state_t.
  - Default constant MULT_WIDTH = 8.
- Shape: one always_ff for state and cnt, one always_comb for next state, one always_comb for outputs.
- No sub-module; the counter is inline.

## Test plan
- Reset in HALT, and Reset asserted in ADD at cnt=3 → next cycle IDLE, Busy=0, Done=0, no further Shift_En.
- IDLE, ClearA_LoadB=1, Run=0 → Clr_A=1 and Ld_B=1 the same cycle; with Run=1 as well → both 0 and CLEAR entered next cycle.
- WIDTH=8, M held 0, Run pulsed 1 cycle → Busy for 17 cycles, 8 Shift_En pulses, Ld_A/Add/Sub never high, Done at cycle 18.
- WIDTH=8, M held 1 → 7 Add pulses, 1 Sub pulse (in ADD7, cycle 16), 8 Ld_A pulses, each followed by Shift_En.
- Run held high through HALT for 5 cycles, then low → Done stays high 5+ cycles, IDLE after the low sample, no restart while Run is held.
- Run dropped at cycle 4 → run still completes with Done at cycle 18; the cnt sequence 0..7 is checked against the Shift_En count.
